// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one shared 4-bit carry-lookahead slice per clock, LSB slice first.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SH_W   = IDX_W + 2;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               accept, last;

  logic [SH_W-1:0]    sh;
  logic [3:0]         sa, sb, p, g, s;
  logic               c0, c1, c2, c3, c4;
  logic [WIDTH-1:0]   sum_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign accept = in_valid && in_ready && !flush;
  assign last   = (idx == IDX_W'(NSLICE - 1));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (flush) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    if (flush || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Current slice: full lookahead carries from the registered carry
  always_comb begin
    sh = {idx, 2'b00};
    sa = 4'(a_r >> sh);
    sb = 4'(b_r >> sh);
    p  = sa ^ sb;
    g  = sa & sb;
    c0 = carry;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    s  = p ^ {c3, c2, c1, c0};
    sum_nxt = (sum & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(s) << sh);
  end

  // Operand capture and per-slice accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      co    <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= a;
            b_r   <= b;
            carry <= ci;
            idx   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          if (!flush) begin
            sum   <= sum_nxt;
            carry <= c4;
            if (last) begin
              co  <= c4;
`ifdef CLA_SEQ_OVF_EN
              ovf <= c3 ^ c4;
`endif
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder (WIDTH=16), drives and samples on falling edges.
module tb_cla_seq_adder;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, ci, flush, busy, out_valid, out_ready, co;
  logic [WIDTH-1:0] a, b, sum;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_err    = 0;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .flush(flush), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .co(co)
`ifdef CLA_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation with out_ready high; operands are scrambled after acceptance
  task automatic do_add(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                        input logic xci, input logic [15:0] es, input logic eco,
                        input logic eov);
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = xa; b = xb; ci = xci; in_valid = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      a = ~xa; b = ~xb; ci = ~xci;
    end while (!out_valid && cyc < 20);
    chk({tag, "_latency"}, 32'(cyc), 32'(NSLICE + 1));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_co"}, 32'(co), 32'(eco));
`ifdef CLA_SEQ_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eov));
`else
    if (eov === 1'bx) $display("note: unknown overflow expectation for %s", tag);
`endif
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    do_add("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_add("fullcar", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_add("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_add("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_add("mixed",   16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0);
    do_add("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: result held, new request ignored until released
    out_ready = 1'b0;
    a = 16'h00FF; b = 16'h0001; ci = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0003; b = 16'h0004;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h0100);
      chk("bp_co", 32'(co), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("bp_after_in_ready", 32'(in_ready), 32'd1);
    chk("bp_after_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    do_add("after_bp", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Flush in IDLE beats in_valid
    flush = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("idle_flush_busy", 32'(busy), 32'd0);

    // Flush mid-RUN with carries in flight
    a = 16'hFFFF; b = 16'h0001; ci = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("flush_busy_run", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (out_valid) seen++;
        @(negedge clk);
      end
      chk("flush_no_valid", 32'(seen), 32'd0);
    end
    do_add("post_flush", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Reset mid-RUN with a concurrent request
    a = 16'h0F0F; b = 16'h00F1; ci = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    #1 chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_co", 32'(co), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("mid_rst_after_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    do_add("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
